// File: rtl/slave_mem_responder_pkg.sv
// slave_mem_responder_pkg: shared types and constants for the slave memory responder
`ifndef DW
`define DW 32
`endif
package slave_resp_pkg;
    typedef enum logic [1:0] {IDLE, ACK_WAIT, RESP_WAIT} state_t;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    typedef struct packed {
        logic cmd;
        logic [31:0] addr;
        logic [`DW-1:0] wdata;
    } req_t;
endpackage

// File: rtl/slave_mem_responder_if.sv
// slave_mem_responder_if: request/ack/response bus between crossbar port and slave
interface slave_mem_responder_if #(
    parameter int DW = `DW,
    parameter int AW = 30
);
    logic req;
    logic cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic ack;
    logic resp;
    logic [DW-1:0] rdata;
    logic [7:0] drop_cnt;
    modport master (output req, cmd, addr, wdata, input ack, resp, rdata, drop_cnt);
    modport slave (input req, cmd, addr, wdata, output ack, resp, rdata, drop_cnt);
endinterface

// File: rtl/slave_mem_responder_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR used to stretch latencies
module lfsr16
    import slave_resp_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state
);
    // shift left, feedback is the parity of the tapped bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SEED;
        else state <= {state[14:0], ^(state & LFSR_TAPS)};
    end
endmodule

// File: rtl/slave_mem_responder.sv
// slave_mem_responder: memory-backed slave with programmable, optionally randomized ack/resp latency
module slave_mem_responder
    import slave_resp_pkg::*;
#(
    parameter int          DW       = `DW,
    parameter int          AW       = 30,
    parameter int          DEPTH    = 256,
    parameter int          ACK_LAT  = 1,
    parameter int          RESP_LAT = 1,
    parameter bit          RAND_DLY = 1'b0,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input logic clk,
    input logic rst_n,
    slave_mem_responder_if.slave bus
);
    localparam int IW = $clog2(DEPTH);

    state_t state, state_n;
    req_t cur, cur_n;
    logic [15:0] cnt, cnt_n, lfsr, rnd, ack_ld, resp_ld;
    logic accept, fire, resp_fire;
    logic [IW-1:0] idx;
    logic [DW-1:0] rd_hold;
    logic [DW-1:0] mem [DEPTH];

    lfsr16 #(.SEED(SEED)) u_lfsr (.clk(clk), .rst_n(rst_n), .state(lfsr));

    assign rnd = RAND_DLY ? {14'd0, lfsr[1:0]} : 16'd0;
    assign ack_ld = 16'(ACK_LAT - 1) + rnd;
    assign resp_ld = 16'(RESP_LAT - 1) + rnd;
    assign accept = state == IDLE && bus.req;
    // a zero ack load fires straight from IDLE so ack lands ACK_LAT cycles after req
    assign fire = (accept && ack_ld == 16'd0) || (state == ACK_WAIT && cnt == 16'd0);
    assign resp_fire = state == RESP_WAIT && cnt == 16'd0;
    assign idx = cur_n.addr[IW-1:0];

    // next state, countdown and the request being served
    always_comb begin
        state_n = state;
        cnt_n = cnt == 16'd0 ? cnt : cnt - 16'd1;
        cur_n = accept ? '{cmd: bus.cmd, addr: 32'(bus.addr), wdata: bus.wdata} : cur;
        if (accept) begin
            state_n = ACK_WAIT;
            cnt_n = ack_ld - 16'd1;
        end
        if (resp_fire) state_n = IDLE;
        if (fire) begin
            state_n = cur_n.cmd ? IDLE : RESP_WAIT;
            cnt_n = cur_n.cmd ? 16'd0 : resp_ld;
        end
    end

    // FSM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            cur <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            cur <= cur_n;
        end
    end

    // registered pulses, read data path and drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ack <= 1'b0;
            bus.resp <= 1'b0;
            bus.rdata <= '0;
            bus.drop_cnt <= '0;
            rd_hold <= '0;
        end else begin
            bus.ack <= fire;
            bus.resp <= resp_fire;
            if (fire && !cur_n.cmd) rd_hold <= mem[idx];
            if (resp_fire) bus.rdata <= rd_hold;
            if (bus.req && state != IDLE && bus.drop_cnt != 8'hFF) bus.drop_cnt <= bus.drop_cnt + 8'd1;
        end
    end

    // memory is not reset; writes commit on the ack edge only
    always_ff @(posedge clk) begin
        if (rst_n && fire && cur_n.cmd) mem[idx] <= cur_n.wdata;
    end
endmodule
